// File: rtl/zap_wb_arbiter_pkg.sv
// Shared types and constants for the ZAP Wishbone code/data arbiter.
package zap_wb_arbiter_pkg;

  localparam int unsigned WB_SEL_W = 4;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_CTI_W = 3;

  localparam logic [WB_CTI_W-1:0] CTI_CLASSIC = 3'b000;
  localparam logic [WB_CTI_W-1:0] CTI_BURST   = 3'b010;
  localparam logic [WB_CTI_W-1:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_C = 2'b01,
    GNT_D = 2'b10
  } arb_state_e;

  // One requester's view of the bus, packed so a grant is a single mux.
  typedef struct packed {
    logic                cyc;
    logic                stb;
    logic                wen;
    logic [WB_SEL_W-1:0] sel;
    logic [WB_DAT_W-1:0] dat;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_CTI_W-1:0] cti;
  } wb_req_t;

endpackage

// File: rtl/zap_wb_arbiter.sv
// Two-master Wishbone arbiter: data has priority over code, with a bounded
// number of back-to-back data wins while code waits. Grants never preempt a cycle.
module zap_wb_arbiter
  import zap_wb_arbiter_pkg::*;
#(
  parameter int unsigned MAX_CONSEC = 32'd4
) (
  input  logic        i_clk,
  input  logic        i_reset,

  input  logic        i_c_wb_cyc,
  input  logic        i_c_wb_stb,
  input  logic        i_c_wb_wen,
  input  logic [3:0]  i_c_wb_sel,
  input  logic [31:0] i_c_wb_dat,
  input  logic [31:0] i_c_wb_adr,
  input  logic [2:0]  i_c_wb_cti,
  output logic        o_c_wb_ack,

  input  logic        i_d_wb_cyc,
  input  logic        i_d_wb_stb,
  input  logic        i_d_wb_wen,
  input  logic [3:0]  i_d_wb_sel,
  input  logic [31:0] i_d_wb_dat,
  input  logic [31:0] i_d_wb_adr,
  input  logic [2:0]  i_d_wb_cti,
  output logic        o_d_wb_ack,

  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_wen,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_dat,
  output logic [31:0] o_wb_adr,
  output logic [2:0]  o_wb_cti,
  input  logic        i_wb_ack
);

  localparam int unsigned CNT_W = (MAX_CONSEC > 0) ? $clog2(MAX_CONSEC + 1) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CONSEC);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  wb_req_t c_req;
  wb_req_t d_req;
  wb_req_t bus;

  logic arb_open;
  logic code_forced;

  assign c_req = '{cyc: i_c_wb_cyc, stb: i_c_wb_stb, wen: i_c_wb_wen, sel: i_c_wb_sel,
                   dat: i_c_wb_dat, adr: i_c_wb_adr, cti: i_c_wb_cti};
  assign d_req = '{cyc: i_d_wb_cyc, stb: i_d_wb_stb, wen: i_d_wb_wen, sel: i_d_wb_sel,
                   dat: i_d_wb_dat, adr: i_d_wb_adr, cti: i_d_wb_cti};

  // The current owner keeps the bus for as long as it holds cyc.
  assign arb_open    = !((state_q == GNT_C) && i_c_wb_cyc) &&
                       !((state_q == GNT_D) && i_d_wb_cyc);
  assign code_forced = i_c_wb_cyc && (starve_cnt_q == MAX_CNT);

  // Next-state and starvation counter.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    if (arb_open) begin
      if (i_d_wb_cyc && !code_forced) begin
        state_d = GNT_D;
        if (!i_c_wb_cyc) begin
          starve_cnt_d = '0;
        end else if (starve_cnt_q != MAX_CNT) begin
          starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
      end else if (i_c_wb_cyc) begin
        state_d      = GNT_C;
        starve_cnt_d = '0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Route the granted requester to the shared bus and the ack back to it.
  always_comb begin
    bus        = '0;
    o_c_wb_ack = 1'b0;
    o_d_wb_ack = 1'b0;
    case (state_q)
      GNT_C: begin
        bus        = c_req;
        o_c_wb_ack = i_wb_ack;
      end
      GNT_D: begin
        bus        = d_req;
        o_d_wb_ack = i_wb_ack;
      end
      default: begin
        bus = '0;
      end
    endcase
  end

  assign o_wb_cyc = bus.cyc;
  assign o_wb_stb = bus.stb;
  assign o_wb_wen = bus.wen;
  assign o_wb_sel = bus.sel;
  assign o_wb_dat = bus.dat;
  assign o_wb_adr = bus.adr;
  assign o_wb_cti = bus.cti;

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Bench for zap_wb_arbiter: directed scenarios pinned with literals, then
// randomized Wishbone traffic checked every cycle against an ownership model.
module tb_zap_wb_arbiter;
  import zap_wb_arbiter_pkg::*;

  localparam int unsigned MAXC = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        c_cyc, c_stb, c_wen;
  logic [3:0]  c_sel;
  logic [31:0] c_dat, c_adr;
  logic [2:0]  c_cti;
  logic        c_ack;
  logic        d_cyc, d_stb, d_wen;
  logic [3:0]  d_sel;
  logic [31:0] d_dat, d_adr;
  logic [2:0]  d_cti;
  logic        d_ack;
  logic        o_wb_cyc, o_wb_stb, o_wb_wen;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_dat, o_wb_adr;
  logic [2:0]  o_wb_cti;
  logic        i_wb_ack;

  always #5 i_clk = ~i_clk;

  zap_wb_arbiter #(.MAX_CONSEC(MAXC)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_c_wb_cyc(c_cyc), .i_c_wb_stb(c_stb), .i_c_wb_wen(c_wen), .i_c_wb_sel(c_sel),
    .i_c_wb_dat(c_dat), .i_c_wb_adr(c_adr), .i_c_wb_cti(c_cti), .o_c_wb_ack(c_ack),
    .i_d_wb_cyc(d_cyc), .i_d_wb_stb(d_stb), .i_d_wb_wen(d_wen), .i_d_wb_sel(d_sel),
    .i_d_wb_dat(d_dat), .i_d_wb_adr(d_adr), .i_d_wb_cti(d_cti), .o_d_wb_ack(d_ack),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_wen(o_wb_wen), .o_wb_sel(o_wb_sel),
    .o_wb_dat(o_wb_dat), .o_wb_adr(o_wb_adr), .o_wb_cti(o_wb_cti), .i_wb_ack(i_wb_ack)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus (0 none, 1 code, 2 data) and how many data wins
  // in a row have happened while code was waiting.
  int   m_owner = 0;
  int   m_cnt   = 0;
  logic check_en = 1'b0;

  always @(posedge i_clk) begin
    if (i_reset) begin
      m_owner = 0;
      m_cnt   = 0;
    end else begin
      bool_keep: begin
        if ((m_owner == 1 && c_cyc) || (m_owner == 2 && d_cyc)) disable bool_keep;
        if (d_cyc && !(c_cyc && m_cnt == MAXC)) begin
          m_owner = 2;
          m_cnt   = c_cyc ? ((m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1) : 0;
        end else if (c_cyc) begin
          m_owner = 1;
          m_cnt   = 0;
        end else begin
          m_owner = 0;
        end
      end
    end
  end

  logic [73:0] exp_bus;
  always @(negedge i_clk) begin
    if (check_en) begin
      case (m_owner)
        1:       exp_bus = {c_cyc, c_stb, c_wen, c_sel, c_dat, c_adr, c_cti};
        2:       exp_bus = {d_cyc, d_stb, d_wen, d_sel, d_dat, d_adr, d_cti};
        default: exp_bus = '0;
      endcase
      chk("bus", 80'({o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_sel, o_wb_dat, o_wb_adr, o_wb_cti}),
          80'(exp_bus));
      chk("c_ack", 80'(c_ack), 80'(m_owner == 1 && i_wb_ack));
      chk("d_ack", 80'(d_ack), 80'(m_owner == 2 && i_wb_ack));
      chk("starve_cnt", 80'(dut.starve_cnt_q), 80'(m_cnt));
    end
  end

  // Random requester: holds cyc until it has collected its beats, then drops it.
  task automatic req_step(input logic ack, input int pct, inout int rem, inout logic cyc,
                          output logic stb, output logic wen, output logic [3:0] sel,
                          output logic [31:0] dat, output logic [31:0] adr,
                          output logic [2:0] cti);
    if (cyc && ack && rem > 0) rem--;
    if (cyc && rem == 0) begin
      cyc = 1'b0;
    end else if (!cyc && $urandom_range(0, 99) < pct) begin
      cyc = 1'b1;
      rem = $urandom_range(1, 6);
    end
    stb = cyc && ($urandom_range(0, 3) != 0);
    wen = 1'($urandom);
    sel = 4'($urandom);
    dat = $urandom;
    adr = $urandom;
    cti = !cyc ? CTI_CLASSIC : (rem == 1 ? CTI_EOB : CTI_BURST);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  int   ack_cnt;
  int   rem_c, rem_d;
  logic ca, da;

  initial begin
    i_reset = 1'b1; i_wb_ack = 1'b0;
    c_cyc = 0; c_stb = 0; c_wen = 0; c_sel = '0; c_dat = '0; c_adr = '0; c_cti = CTI_CLASSIC;
    d_cyc = 0; d_stb = 0; d_wen = 0; d_sel = '0; d_dat = '0; d_adr = '0; d_cti = CTI_CLASSIC;
    step(); step();
    check_en = 1'b1;
    @(negedge i_clk);
    chk("rst_cyc", 80'(o_wb_cyc), 80'(0));
    chk("rst_acks", 80'({c_ack, d_ack}), 80'(0));

    // Spurious ack while idle
    step(); i_reset = 1'b0; i_wb_ack = 1'b1;
    @(negedge i_clk);
    chk("spurious_acks", 80'({c_ack, d_ack}), 80'(0));

    // Data-only classic transaction
    step(); i_wb_ack = 1'b0; d_cyc = 1; d_stb = 1; d_adr = 32'h100; d_cti = CTI_CLASSIC;
    @(negedge i_clk);
    chk("d_arb_cycle_cyc", 80'(o_wb_cyc), 80'(0));
    step();
    @(negedge i_clk);
    chk("d_adr", 80'(o_wb_adr), 80'(32'h100));
    chk("d_cyc", 80'(o_wb_cyc), 80'(1));
    step(); i_wb_ack = 1'b1;
    @(negedge i_clk);
    chk("d_ack_pulse", 80'({c_ack, d_ack}), 80'(2'b01));
    step(); i_wb_ack = 1'b0; d_cyc = 0; d_stb = 0;
    step(); i_wb_ack = 1'b1;
    @(negedge i_clk);
    chk("d_back_idle_ack", 80'({c_ack, d_ack, o_wb_cyc}), 80'(0));

    // Simultaneous request: data first, code follows without an idle cycle
    step(); i_wb_ack = 1'b0;
    c_cyc = 1; c_stb = 1; c_adr = 32'hC00; d_cyc = 1; d_stb = 1; d_adr = 32'hD00;
    step();
    @(negedge i_clk);
    chk("sim_data_first", 80'(o_wb_adr), 80'(32'hD00));
    step(); d_cyc = 0; d_stb = 0;
    step();
    @(negedge i_clk);
    chk("sim_code_adr", 80'(o_wb_adr), 80'(32'hC00));
    chk("sim_no_bubble", 80'(o_wb_cyc), 80'(1));

    // Code 16-beat burst; data requests at beat 3 and must wait
    ack_cnt = 0;
    for (int b = 0; b < 16; b++) begin
      step(); i_wb_ack = 1'b1; c_cti = (b == 15) ? CTI_EOB : CTI_BURST;
      if (b == 3) begin d_cyc = 1; d_stb = 1; d_adr = 32'hD40; d_cti = CTI_BURST; end
      @(negedge i_clk);
      if (c_ack) ack_cnt++;
    end
    chk("burst_code_acks", 80'(ack_cnt), 80'(16));
    step(); i_wb_ack = 1'b0; c_cyc = 0; c_stb = 0; c_cti = CTI_CLASSIC;
    step();
    @(negedge i_clk);
    chk("burst_then_data", 80'(o_wb_adr), 80'(32'hD40));

    // Reset in the middle of a data burst
    for (int b = 0; b < 4; b++) begin
      step(); i_wb_ack = 1'b1;
    end
    step(); i_reset = 1'b1;
    step(); i_reset = 1'b0;
    @(negedge i_clk);
    chk("rst_abort_cyc", 80'(o_wb_cyc), 80'(0));
    chk("rst_abort_acks", 80'({c_ack, d_ack}), 80'(0));
    chk("rst_abort_cnt", 80'(dut.starve_cnt_q), 80'(0));
    step(); i_wb_ack = 1'b0; d_cyc = 0; d_stb = 0; d_cti = CTI_CLASSIC;

    // Randomized traffic, checked every cycle by the model
    rem_c = 0; rem_d = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge i_clk);
      ca = c_ack; da = d_ack;
      step();
      if ($urandom_range(0, 299) == 0) begin
        i_reset = 1'b1;
        c_cyc = 0; c_stb = 0; d_cyc = 0; d_stb = 0; rem_c = 0; rem_d = 0;
      end else begin
        i_reset = 1'b0;
        req_step(ca, 30, rem_c, c_cyc, c_stb, c_wen, c_sel, c_dat, c_adr, c_cti);
        req_step(da, 50, rem_d, d_cyc, d_stb, d_wen, d_sel, d_dat, d_adr, d_cti);
      end
      i_wb_ack = ($urandom_range(0, 2) != 0);
    end

    @(negedge i_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
